// File: rtl/decode_ctrl_pipe.sv
// RV32I decode into a valid/ready decode->execute register with load-use bubble insertion.
// Define DECODE_MEXT_EN to also decode the RV32M multiply/divide group (alusel 16-23).
module decode_ctrl_pipe #(
    parameter int DWIDTH   = 32,
    parameter int LOAD_LAT = 0,
    parameter int ASWIDTH  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DWIDTH-1:0]  insn_i,
    input  logic               insn_valid_i,
    output logic               insn_ready_o,
    input  logic               flush_i,
    output logic               ctrl_valid_o,
    input  logic               ctrl_ready_i,
    output logic               pcsel_o,
    output logic               immsel_o,
    output logic               regwren_o,
    output logic               rs1sel_o,
    output logic               rs2sel_o,
    output logic               memren_o,
    output logic               memwren_o,
    output logic [1:0]         wbsel_o,
    output logic [ASWIDTH-1:0] alusel_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o,
    output logic [2:0]         funct3_o,
    output logic               illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] LAT     = 3'(LOAD_LAT);

    typedef struct packed {
        logic               pcsel;
        logic               immsel;
        logic               regwren;
        logic               rs1sel;
        logic               rs2sel;
        logic               memren;
        logic               memwren;
        logic [1:0]         wbsel;
        logic [ASWIDTH-1:0] alusel;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic               illegal;
    } ctrl_t;

    function automatic logic [ASWIDTH-1:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ASWIDTH'(0);
            3'b001:  return ASWIDTH'(2);
            3'b010:  return ASWIDTH'(3);
            3'b011:  return ASWIDTH'(4);
            3'b100:  return ASWIDTH'(5);
            3'b101:  return ASWIDTH'(6);
            3'b110:  return ASWIDTH'(8);
            default: return ASWIDTH'(9);
        endcase
    endfunction

    function automatic logic src_hit(input logic [4:0] r, input logic u1, input logic u2,
                                     input logic [4:0] s1, input logic [4:0] s2);
        return (r != 5'd0) && ((u1 && (s1 == r)) || (u2 && (s2 == r)));
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = insn_i[6:0];
    assign funct3 = insn_i[14:12];
    assign funct7 = insn_i[31:25];

    ctrl_t dec;
    logic  use_rs1, use_rs2;

    always_comb begin
        dec        = '0;
        dec.rd     = insn_i[11:7];
        dec.rs1    = insn_i[19:15];
        dec.rs2    = insn_i[24:20];
        dec.funct3 = funct3;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.immsel = 1'b1; dec.rs2sel = 1'b1; dec.regwren = 1'b1;
                dec.alusel = ASWIDTH'(10);
            end
            OPC_AUIPC: begin
                dec.immsel = 1'b1; dec.rs1sel = 1'b1; dec.rs2sel = 1'b1; dec.regwren = 1'b1;
            end
            OPC_JAL: begin
                dec.pcsel = 1'b1; dec.immsel = 1'b1; dec.rs1sel = 1'b1; dec.rs2sel = 1'b1;
                dec.regwren = 1'b1; dec.wbsel = 2'b10;
            end
            OPC_JALR: begin
                dec.pcsel = 1'b1; dec.immsel = 1'b1; dec.rs2sel = 1'b1;
                dec.regwren = 1'b1; dec.wbsel = 2'b10; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.pcsel = 1'b1; dec.immsel = 1'b1; dec.rs1sel = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.immsel = 1'b1; dec.rs2sel = 1'b1; dec.regwren = 1'b1;
                dec.memren = 1'b1; dec.wbsel = 2'b01; use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.immsel = 1'b1; dec.rs2sel = 1'b1; dec.memwren = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec.immsel = 1'b1; dec.rs2sel = 1'b1; dec.regwren = 1'b1; use_rs1 = 1'b1;
                dec.alusel = base_alu(funct3);
                // Only the shift-immediates carry a funct7 field; elsewhere those bits are immediate.
                if (funct3 == 3'b001 && funct7 != F7_BASE) dec.illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)       dec.alusel  = ASWIDTH'(7);
                    else if (funct7 != F7_BASE) dec.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                dec.regwren = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct7)
                    F7_BASE: dec.alusel = base_alu(funct3);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      dec.alusel  = ASWIDTH'(1);
                        else if (funct3 == 3'b101) dec.alusel  = ASWIDTH'(7);
                        else                       dec.illegal = 1'b1;
                    end
`ifdef DECODE_MEXT_EN
                    7'b0000001: dec.alusel = ASWIDTH'({2'b10, funct3});
`endif
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.pcsel   = 1'b0; dec.immsel = 1'b0; dec.regwren = 1'b0; dec.rs1sel = 1'b0;
            dec.rs2sel  = 1'b0; dec.memren = 1'b0; dec.memwren = 1'b0;
            dec.wbsel   = '0;   dec.alusel = '0;
        end
        if (dec.rd == 5'd0) dec.regwren = 1'b0;
    end

    ctrl_t      ctrl_q, ctrl_d;
    logic       ctrl_valid_q, ctrl_valid_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] pend_rd_q, pend_rd_d;
    logic       hazard, accept, depart;

    assign hazard = (ctrl_valid_q && ctrl_q.memren &&
                     src_hit(ctrl_q.rd, use_rs1, use_rs2, dec.rs1, dec.rs2)) ||
                    ((cnt_q != 3'd0) && src_hit(pend_rd_q, use_rs1, use_rs2, dec.rs1, dec.rs2));
    assign insn_ready_o = (!ctrl_valid_q || ctrl_ready_i) && !hazard && !flush_i;
    assign accept       = insn_valid_i && insn_ready_o;
    assign depart       = ctrl_valid_q && ctrl_ready_i && ctrl_q.memren;

    // NOTE: next state is built here with blocking assignments from a full default; only the
    // always_ff below uses non-blocking assignments, so no latch and no ordering race.
    always_comb begin
        ctrl_d       = ctrl_q;
        ctrl_valid_d = ctrl_valid_q;
        cnt_d        = cnt_q;
        pend_rd_d    = pend_rd_q;
        if (flush_i) begin
            ctrl_valid_d = 1'b0;
            cnt_d        = 3'd0;
        end else begin
            if (accept) begin
                ctrl_d       = dec;
                ctrl_valid_d = 1'b1;
            end else if (ctrl_ready_i) begin
                ctrl_valid_d = 1'b0;
            end
            if (depart) begin
                pend_rd_d = ctrl_q.rd;
                cnt_d     = LAT;
            end else if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            cnt_q        <= 3'd0;
            pend_rd_q    <= 5'd0;
        end else begin
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            cnt_q        <= cnt_d;
            pend_rd_q    <= pend_rd_d;
        end
    end

    assign ctrl_valid_o = ctrl_valid_q;
    assign pcsel_o      = ctrl_q.pcsel;
    assign immsel_o     = ctrl_q.immsel;
    assign regwren_o    = ctrl_q.regwren;
    assign rs1sel_o     = ctrl_q.rs1sel;
    assign rs2sel_o     = ctrl_q.rs2sel;
    assign memren_o     = ctrl_q.memren;
    assign memwren_o    = ctrl_q.memwren;
    assign wbsel_o      = ctrl_q.wbsel;
    assign alusel_o     = ctrl_q.alusel;
    assign rd_o         = ctrl_q.rd;
    assign rs1_o        = ctrl_q.rs1;
    assign rs2_o        = ctrl_q.rs2;
    assign funct3_o     = ctrl_q.funct3;
    assign illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed scenarios plus random traffic against
// a cycle-stamped reference model (last load departure time, not a countdown register).
module tb_decode_ctrl_pipe;

    localparam int LAT = 1;

    localparam logic [31:0] I_ADD3 = 32'h002081B3;
    localparam logic [31:0] I_ADD7 = 32'h002083B3;
    localparam logic [31:0] I_LW5  = 32'h0000A283;
    localparam logic [31:0] I_ADD6 = 32'h00528333;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_MUL  = 32'h022081B3;

    typedef struct packed {
        logic       pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren;
        logic [1:0] wbsel;
        logic [4:0] alusel;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] funct3;
        logic       illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] insn_i = '0;
    logic        insn_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ctrl_ready_i = 1'b0;
    logic        insn_ready_o, ctrl_valid_o;
    logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o;
    logic [1:0]  wbsel_o;
    logic [4:0]  alusel_o, rd_o, rs1_o, rs2_o;
    logic [2:0]  funct3_o;
    logic        illegal_o;

    decode_ctrl_pipe #(.DWIDTH(32), .LOAD_LAT(LAT), .ASWIDTH(5)) dut (
        .clk(clk), .reset(reset), .insn_i(insn_i), .insn_valid_i(insn_valid_i),
        .insn_ready_o(insn_ready_o), .flush_i(flush_i), .ctrl_valid_o(ctrl_valid_o),
        .ctrl_ready_i(ctrl_ready_i), .pcsel_o(pcsel_o), .immsel_o(immsel_o),
        .regwren_o(regwren_o), .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
        .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o),
        .alusel_o(alusel_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .funct3_o(funct3_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: output register contents and the most recent load departure.
    bit   m_valid;
    exp_t m_ctrl;
    int   cyc;
    int   ld_cyc;
    logic [4:0] ld_rd;
    bit   last_acc, last_rdy;

    function automatic exp_t ref_decode(input logic [31:0] ins);
        int   base_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        exp_t e = '0;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.funct3 = f3;
        if (op == 7'h37) begin
            e.immsel = 1; e.rs2sel = 1; e.regwren = 1; e.alusel = 5'd10;
        end else if (op == 7'h17) begin
            e.immsel = 1; e.rs1sel = 1; e.rs2sel = 1; e.regwren = 1;
        end else if (op == 7'h6F) begin
            e.pcsel = 1; e.immsel = 1; e.rs1sel = 1; e.rs2sel = 1; e.regwren = 1; e.wbsel = 2;
        end else if (op == 7'h67) begin
            e.pcsel = 1; e.immsel = 1; e.rs2sel = 1; e.regwren = 1; e.wbsel = 2;
        end else if (op == 7'h63) begin
            e.pcsel = 1; e.immsel = 1; e.rs1sel = 1;
        end else if (op == 7'h03) begin
            e.immsel = 1; e.rs2sel = 1; e.regwren = 1; e.memren = 1; e.wbsel = 1;
        end else if (op == 7'h23) begin
            e.immsel = 1; e.rs2sel = 1; e.memwren = 1;
        end else if (op == 7'h13) begin
            e.immsel = 1; e.rs2sel = 1; e.regwren = 1; e.alusel = 5'(base_tab[f3]);
            if (f3 == 3'd1 && f7 != 7'h00) e.illegal = 1;
            if (f3 == 3'd5 && f7 == 7'h20) e.alusel = 5'd7;
            if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) e.illegal = 1;
        end else if (op == 7'h33) begin
            e.regwren = 1;
            if (f7 == 7'h00) e.alusel = 5'(base_tab[f3]);
            else if (f7 == 7'h20 && f3 == 3'd0) e.alusel = 5'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alusel = 5'd7;
`ifdef DECODE_MEXT_EN
            else if (f7 == 7'h01) e.alusel = 5'(16 + int'(f3));
`endif
            else e.illegal = 1;
        end else begin
            e.illegal = 1;
        end
        if (e.illegal) e = '{rd: e.rd, rs1: e.rs1, rs2: e.rs2, funct3: e.funct3, illegal: 1'b1, default: '0};
        if (e.rd == 5'd0) e.regwren = 0;
        return e;
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [6:0] op = ins[6:0];
        bit u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        bit u2 = op inside {7'h33, 7'h23, 7'h63};
        return (r != 5'd0) && ((u1 && ins[19:15] == r) || (u2 && ins[24:20] == r));
    endfunction

    function automatic logic [63:0] got_vec();
        return 64'({pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o,
                    wbsel_o, alusel_o, rd_o, rs1_o, rs2_o, funct3_o, illegal_o});
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ctrl = '0; ld_cyc = -100; ld_rd = '0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model, return at posedge+1.
    task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
        bit haz, exp_rdy, acc, dep;
        insn_valid_i = v; insn_i = ins; ctrl_ready_i = rdy; flush_i = fl;
        @(negedge clk);
        haz = (m_valid && m_ctrl.memren && reads_reg(ins, m_ctrl.rd)) ||
              (cyc > ld_cyc && cyc <= ld_cyc + LAT && reads_reg(ins, ld_rd));
        exp_rdy = !fl && (!m_valid || rdy) && !haz;
        check("insn_ready", 64'(insn_ready_o), 64'(exp_rdy));
        check("ctrl_valid", 64'(ctrl_valid_o), 64'(m_valid));
        if (m_valid) check("ctrl_fields", got_vec(), 64'(m_ctrl));
        last_rdy = insn_ready_o;
        last_acc = v && insn_ready_o;
        acc = v && exp_rdy;
        dep = m_valid && rdy && m_ctrl.memren;
        if (fl) begin
            m_valid = 0; ld_cyc = -100;
        end else begin
            if (dep) begin ld_rd = m_ctrl.rd; ld_cyc = cyc; end
            if (acc) begin m_valid = 1; m_ctrl = ref_decode(ins); end
            else if (rdy) m_valid = 0;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0] op;
        logic [6:0] f7 = 7'($urandom);
        logic [2:0] f3 = 3'($urandom);
        logic [4:0] rd = 5'($urandom_range(0, 3));
        logic [4:0] r1 = 5'($urandom_range(0, 3));
        logic [4:0] r2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0, 1: begin
                op = 7'h33;
                case ($urandom_range(0, 3))
                    0, 1:    f7 = 7'h00;
                    2:       f7 = 7'h20;
                    default: f7 = 7'h01;
                endcase
            end
            2, 3: begin
                op = 7'h13;
                if ($urandom_range(0, 1) == 1) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            4:  op = 7'h37;
            5:  op = 7'h17;
            6:  op = 7'h6F;
            7:  op = 7'h67;
            8:  op = 7'h63;
            9:  op = 7'h03;
            10: op = 7'h23;
            default: begin
                case ($urandom_range(0, 3))
                    0:       op = 7'h0F;
                    1:       op = 7'h73;
                    2:       op = 7'h7F;
                    default: op = 7'h0B;
                endcase
            end
        endcase
        return {f7, r2, r1, f3, rd, op};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        logic [31:0] cur;
        cyc = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(ctrl_valid_o), 64'd0);
        check("rst_fields", got_vec(), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(insn_ready_o), 64'd1);

        // add x3,x1,x2
        step(1, I_ADD3, 1, 0);
        check("add_alusel", 64'(alusel_o), 64'd0);
        check("add_regwren", 64'(regwren_o), 64'd1);
        check("add_rs2sel", 64'(rs2sel_o), 64'd0);
        check("add_wbsel", 64'(wbsel_o), 64'd0);
        check("add_rd", 64'(rd_o), 64'd3);
        step(0, '0, 1, 0);

        // lw x5 then dependent add x6,x5,x5
        step(1, I_LW5, 1, 0);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, I_ADD6, 1, 0);
            if (last_acc) break;
            stalls++;
        end
        check("lu_stalls", 64'(stalls), 64'(LAT + 1));

        // jal held under back-pressure
        step(1, I_JAL, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, I_ADD3, 0, 0);
            check("jal_ready_low", 64'(last_rdy), 64'd0);
            check("jal_pcsel", 64'(pcsel_o), 64'd1);
            check("jal_wbsel", 64'(wbsel_o), 64'd2);
            check("jal_rs1sel", 64'(rs1sel_o), 64'd1);
        end
        step(0, '0, 1, 0);

        // flush with a valid output and a pending load window
        step(1, I_LW5, 1, 0);
        step(1, I_ADD7, 1, 0);
        step(0, '0, 0, 1);
        check("flush_valid", 64'(ctrl_valid_o), 64'd0);
        step(1, I_ADD6, 1, 0);
        check("flush_dep_acc", 64'(last_acc), 64'd1);
        step(0, '0, 1, 0);

        // mul x3,x1,x2
        step(1, I_MUL, 1, 0);
`ifdef DECODE_MEXT_EN
        check("mul_alusel", 64'(alusel_o), 64'd16);
        check("mul_illegal", 64'(illegal_o), 64'd0);
        check("mul_regwren", 64'(regwren_o), 64'd1);
`else
        check("mul_illegal", 64'(illegal_o), 64'd1);
        check("mul_regwren", 64'(regwren_o), 64'd0);
`endif
        step(0, '0, 1, 0);

        // asynchronous reset in the middle of a load-use stall
        step(1, I_LW5, 1, 0);
        step(1, I_ADD6, 0, 0);
        #2;
        insn_valid_i = 0; ctrl_ready_i = 1; insn_i = '0;
        reset = 1'b1;
        #1;
        check("arst_valid", 64'(ctrl_valid_o), 64'd0);
        check("arst_fields", got_vec(), 64'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("arst_ready", 64'(insn_ready_o), 64'd1);
        step(1, I_ADD6, 1, 0);
        check("arst_dep_acc", 64'(last_acc), 64'd1);

        // random traffic; an instruction is held until accepted
        cur = rand_insn();
        for (int i = 0; i < 800; i++) begin
            bit v, rdy, fl;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            step(v, cur, rdy, fl);
            if (last_acc || !v) cur = rand_insn();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, handshaked successor to the decode-stage control generator: decodes RV32I (optionally RV32M) instructions into control bits, holds them in a decode→execute pipeline register with valid/ready flow control, and inserts bubbles for load-use hazards. It sits between the fetch/decode register and the execute stage, replacing the purely combinational control path.

## Interface
- DWIDTH, 32, instruction width; only bits [31:0] are decoded.
- LOAD_LAT, 0, extra hazard cycles after a load leaves the output register; legal range 0–7.
- ASWIDTH, 5, width of alusel_o; must be ≥5.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- insn_i  in  DWIDTH  instruction.
- insn_valid_i  in  1  insn_i valid.
- insn_ready_o  out  1  block accepts insn_i this cycle.
- flush_i  in  1  kill the output register and hazard state.
- ctrl_valid_o  out  1  output register holds a valid decoded instruction.
- ctrl_ready_i  in  1  execute stage consumes the output register.
- pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o  out  1 each  control bits (encoding below).
- wbsel_o  out  2  00 ALU, 01 memory, 10 PC+4.
- alusel_o  out  ASWIDTH  ALU operation.
- rd_o, rs1_o, rs2_o  out  5 each  register indices.
- funct3_o  out  3  passed through for branch/memory sizing.
- illegal_o  out  1  unrecognised encoding.

## Operation
- Decode: pcsel=1 for JAL/JALR/BRANCH; immsel=1 for all but OP; rs1sel=1 (PC) for AUIPC/JAL/BRANCH; rs2sel=1 (imm) for all but OP/BRANCH; regwren=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR and rd≠0; memren for LOAD; memwren for STORE; wbsel 01 for LOAD, 10 for JAL/JALR.
- alusel: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI). LOAD/STORE/AUIPC/JAL/JALR/BRANCH use ADD.
- Unknown opcode or funct7: illegal_o=1, all enables (regwren, memren, memwren, pcsel) 0; still delivered with ctrl_valid_o=1.
- Handshake: accept = insn_valid_i && insn_ready_o; insn_ready_o = (!ctrl_valid_o || ctrl_ready_i) && !hazard && !flush_i.
- Output register loads on accept; ctrl_valid_o clears when consumed without a new accept; outputs hold while ctrl_valid_o && !ctrl_ready_i.
- rs1 used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR; rs2 used by OP, STORE, BRANCH. Unused sources and index 0 never hazard.
- Hazard = (ctrl_valid_o && memren_o && rd_o matches a used source) || (cnt≠0 && pend_rd matches a used source).
- Load departure (ctrl_valid_o && ctrl_ready_i && memren_o): pend_rd←rd_o, cnt←LOAD_LAT; otherwise cnt decrements to 0 and saturates.
- flush_i: next cycle ctrl_valid_o=0, cnt=0; dropped input is not accepted. Flush beats any simultaneous accept or departure.

## Timing
- Latency 1 cycle from accept to ctrl_valid_o.
- Throughput 1 instruction/cycle with no hazards.
- Load followed by a dependent instruction, ctrl_ready_i=1: LOAD_LAT+1 stall cycles.
- Reset: every output 0 (ctrl_valid_o=0, alusel_o=0, wbsel_o=00, illegal_o=0), insn_ready_o=1 after reset deasserts, cnt=0, pend_rd=0. Reset mid-stall discards held instruction and hazard state.

## Configuration
- DECODE_MEXT_EN defined: OP with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to alusel 16–23, with regwren per rd and wbsel 00.
- Undefined: those encodings raise illegal_o=1 with enables 0.

## Test plan
- add x3,x1,x2 (0x002081B3) valid, ctrl_ready_i=1 -> next cycle ctrl_valid_o=1, alusel 0, regwren 1, rs2sel 0, wbsel 00, rd_o=3.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333), LOAD_LAT=1 -> insn_ready_o low exactly 2 cycles; add appears 3 cycles after lw.
- ctrl_ready_i=0 for 4 cycles with jal x1,8 (0x008000EF) held -> outputs stable (pcsel 1, wbsel 10, rs1sel 1), insn_ready_o=0 throughout.
- flush_i asserted with valid output and cnt=1 -> next cycle ctrl_valid_o=0; dependent instruction accepted immediately.
- mul x3,x1,x2 (0x022081B3) -> alusel 16, illegal 0 with DECODE_MEXT_EN; illegal 1, regwren 0 without.
- reset asserted asynchronously mid-stall -> all outputs 0 immediately, no stale instruction after release.
